// File: rtl/interface_hcsr04_multi.sv
// Multi-channel HC-SR04 controller. One shared FSM and datapath trigger the selected
// sensor, time its echo, and store a channel-tagged width or timeout result.
module interface_hcsr04_multi #(
  parameter int N_CANAIS       = 4,
  parameter int W_CANAL        = 2,
  parameter int LARGURA_MEDIDA = 22,
  parameter int TRIGGER_CICLOS = 500,
  parameter int TIMEOUT_CICLOS = 1500000,
  parameter int PERIODO_AUTO   = 3000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      medir,
  input  logic                      modo,
  input  logic                      varredura,
  input  logic [W_CANAL-1:0]        canal_sel,
  input  logic [N_CANAIS-1:0]       echo,
  output logic [N_CANAIS-1:0]       trigger,
  output logic [LARGURA_MEDIDA-1:0] medida,
  output logic [W_CANAL-1:0]        canal_medida,
  output logic                      timeout,
  output logic                      pronto,
  output logic                      ocupado,
  output logic [3:0]                db_estado
);

  localparam int W_TRIG = $clog2(TRIGGER_CICLOS) + 1;
  localparam int W_TO   = $clog2(TIMEOUT_CICLOS) + 1;
  localparam int W_AUTO = $clog2(PERIODO_AUTO) + 1;
  localparam logic [W_TRIG-1:0] TRIG_FIM = W_TRIG'(TRIGGER_CICLOS - 1);
  localparam logic [W_TO-1:0]   TO_FIM   = W_TO'(TIMEOUT_CICLOS - 1);
  localparam logic [W_AUTO-1:0] AUTO_FIM = W_AUTO'(PERIODO_AUTO - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDIDA        = 4'h4,
    ARMAZENAMENTO = 4'h5,
    ESPERA_AUTO   = 4'h7,
    FINAL         = 4'hF
  } estado_t;

  estado_t state, state_next;

  logic [N_CANAIS-1:0]       echo_s1, echo_s2;
  logic [W_CANAL-1:0]        canal, canal_inicial;
  logic [W_TRIG-1:0]         trig_cnt;
  logic [W_TO-1:0]           to_cnt;
  logic [LARGURA_MEDIDA-1:0] width_cnt;
  logic [W_AUTO-1:0]         auto_cnt;
  logic                      flag;
  logic                      echo_canal;
  logic                      canal_ultimo;

  // Out-of-range channel requests fall back to channel 0.
  assign canal_inicial = (32'(canal_sel) < 32'(N_CANAIS)) ? canal_sel : '0;
  assign canal_ultimo  = (32'(canal) >= 32'(N_CANAIS - 1));
  assign echo_canal    = echo_s2[canal];

  always_ff @(posedge clock) begin
    if (!reset) state <= INICIAL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    db_estado  = state;
    trigger    = '0;
    pronto     = 1'b0;
    ocupado    = 1'b1;
    case (state)
      INICIAL: begin
        ocupado = 1'b0;
        if (modo)       state_next = ESPERA_AUTO;
        else if (medir) state_next = PREPARACAO;
      end
      ESPERA_AUTO: begin
        ocupado = 1'b0;
        if (!modo)                 state_next = INICIAL;
        else if (auto_cnt == AUTO_FIM) state_next = PREPARACAO;
      end
      PREPARACAO: state_next = ENVIA_TRIGGER;
      ENVIA_TRIGGER: begin
        trigger[canal] = 1'b1;
        if (trig_cnt == TRIG_FIM) state_next = ESPERA_ECHO;
      end
      ESPERA_ECHO: begin
        if (echo_canal)            state_next = MEDIDA;
        else if (to_cnt == TO_FIM) state_next = ARMAZENAMENTO;
      end
      MEDIDA: begin
        if (to_cnt >= TO_FIM || !echo_canal) state_next = ARMAZENAMENTO;
      end
      ARMAZENAMENTO: state_next = FINAL;
      FINAL: begin
        pronto = 1'b1;
        if (varredura && !canal_ultimo) state_next = PREPARACAO;
        else if (modo)                  state_next = ESPERA_AUTO;
        else                            state_next = INICIAL;
      end
      default: begin
        state_next = INICIAL;
        db_estado  = 4'hE;
      end
    endcase
  end

  // Timeout uses >= in MEDIDA so an echo arriving on the last window cycle cannot wrap the counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      echo_s1      <= '0;
      echo_s2      <= '0;
      canal        <= '0;
      trig_cnt     <= '0;
      to_cnt       <= '0;
      width_cnt    <= '0;
      auto_cnt     <= '0;
      flag         <= 1'b0;
      medida       <= '0;
      canal_medida <= '0;
      timeout      <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      case (state)
        INICIAL: begin
          auto_cnt <= '0;
          if (state_next != INICIAL) canal <= varredura ? '0 : canal_inicial;
        end
        ESPERA_AUTO: begin
          auto_cnt <= auto_cnt + 1'b1;
          if (state_next == PREPARACAO) canal <= varredura ? '0 : canal_inicial;
        end
        PREPARACAO: begin
          trig_cnt  <= '0;
          to_cnt    <= '0;
          width_cnt <= '0;
          flag      <= 1'b0;
        end
        ENVIA_TRIGGER: trig_cnt <= trig_cnt + 1'b1;
        ESPERA_ECHO: begin
          to_cnt <= to_cnt + 1'b1;
          if (echo_canal)            width_cnt <= LARGURA_MEDIDA'(1);
          else if (to_cnt == TO_FIM) flag <= 1'b1;
        end
        MEDIDA: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_cnt >= TO_FIM)                     flag <= 1'b1;
          else if (echo_canal && width_cnt != '1) width_cnt <= width_cnt + 1'b1;
        end
        ARMAZENAMENTO: begin
          medida       <= flag ? '1 : width_cnt;
          canal_medida <= canal;
          timeout      <= flag;
        end
        FINAL: begin
          auto_cnt <= '0;
          if (varredura && !canal_ultimo) canal <= canal + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Scoreboard bench for interface_hcsr04_multi: sensor models answer triggers, a reference
// model predicts each stored result and a monitor checks every pronto pulse.
module tb_interface_hcsr04_multi;

  localparam int N    = 4;
  localparam int W    = 2;
  localparam int L    = 12;
  localparam int TRIG = 5;
  localparam int TO   = 200;
  localparam int PER  = 400;
  localparam int ALL1 = (1 << L) - 1;

  logic          clock, reset, medir, modo, varredura;
  logic [W-1:0]  canal_sel;
  wire  [N-1:0]  echo;
  logic [N-1:0]  trigger;
  logic [L-1:0]  medida;
  logic [W-1:0]  canal_medida;
  logic          timeout, pronto, ocupado;
  logic [3:0]    db_estado;

  logic          medir3;
  logic [1:0]    canal_sel3;
  logic [2:0]    echo3, trigger3;
  logic [L-1:0]  medida3;
  logic [1:0]    canal_medida3;
  logic          timeout3, pronto3, ocupado3;
  logic [3:0]    db_estado3;

  typedef struct {
    int medida;
    int canal;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, failed = 0;
  int   cyc = 0, pronto_count = 0, pronto_cyc = 0, trig_fall_cyc = 0, trig_run = 0;
  bit   trig_check_en = 1'b1, watch_busy = 1'b0;
  int   busy_drops = 0;
  int   cfg_delay[N] = '{default: 1};
  int   cfg_width[N] = '{default: 0};

  interface_hcsr04_multi #(
    .N_CANAIS(N), .W_CANAL(W), .LARGURA_MEDIDA(L),
    .TRIGGER_CICLOS(TRIG), .TIMEOUT_CICLOS(TO), .PERIODO_AUTO(PER)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir), .modo(modo), .varredura(varredura),
    .canal_sel(canal_sel), .echo(echo), .trigger(trigger), .medida(medida),
    .canal_medida(canal_medida), .timeout(timeout), .pronto(pronto),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  interface_hcsr04_multi #(
    .N_CANAIS(3), .W_CANAL(2), .LARGURA_MEDIDA(L),
    .TRIGGER_CICLOS(TRIG), .TIMEOUT_CICLOS(TO), .PERIODO_AUTO(PER)
  ) dut3 (
    .clock(clock), .reset(reset), .medir(medir3), .modo(1'b0), .varredura(1'b0),
    .canal_sel(canal_sel3), .echo(echo3), .trigger(trigger3), .medida(medida3),
    .canal_medida(canal_medida3), .timeout(timeout3), .pronto(pronto3),
    .ocupado(ocupado3), .db_estado(db_estado3)
  );

  assign echo3 = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Each sensor answers a falling trigger with a pulse of the configured delay and width.
  for (genvar g = 0; g < N; g++) begin : sensor
    logic e = 1'b0;
    assign echo[g] = e;
    initial begin
      forever begin
        @(negedge trigger[g]);
        if (cfg_width[g] > 0) begin
          repeat (cfg_delay[g]) @(posedge clock);
          #1 e = 1'b1;
          repeat (cfg_width[g]) @(posedge clock);
          #1 e = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    tests++;
    if (actual < lo || actual > hi) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Reference: the echo must end inside the timeout window after trigger fall, else all-ones.
  function automatic exp_t modelResult(input int ch, input int d, input int w);
    exp_t r;
    r.canal = ch;
    if (w == 0 || d + w + 2 >= TO) begin
      r.medida = ALL1;
      r.to     = 1;
    end else begin
      r.medida = (w > ALL1) ? ALL1 : w;
      r.to     = 0;
    end
    return r;
  endfunction

  task automatic pushExpected(input int ch, input int d, input int w);
    cfg_delay[ch] = d;
    cfg_width[ch] = w;
    exp_q.push_back(modelResult(ch, d, w));
  endtask

  task automatic applyStimulus(input int ch, input bit sweep);
    @(negedge clock);
    canal_sel = W'(ch);
    varredura = sweep;
    medir     = 1'b1;
    @(negedge clock);
    medir     = 1'b0;
  endtask

  task automatic waitPronto(input int target, input int budget);
    int n = 0;
    while (pronto_count < target && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (pronto_count < target) checkOutput("wait_pronto", pronto_count, target);
  endtask

  task automatic waitState(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado != s && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (db_estado != s) checkOutput("wait_state", db_estado, s);
  endtask

  // Scoreboard monitor: every pronto pops one prediction.
  always @(negedge clock) begin
    if (pronto) begin
      exp_t e;
      pronto_count++;
      pronto_cyc = cyc;
      if (exp_q.size() == 0) checkOutput("unexpected_pronto", 1, 0);
      else begin
        e = exp_q.pop_front();
        checkOutput("medida", medida, e.medida);
        checkOutput("canal_medida", canal_medida, e.canal);
        checkOutput("timeout", timeout, e.to);
      end
    end
  end

  always @(negedge clock) begin
    if (trigger != '0) begin
      if (trig_run == 0) checkOutput("trigger_onehot", $countones(trigger), 1);
      trig_run++;
    end else if (trig_run != 0) begin
      if (trig_check_en) checkOutput("trigger_len", trig_run, TRIG);
      trig_fall_cyc = cyc;
      trig_run      = 0;
    end
    if (watch_busy && !ocupado) busy_drops++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base, t1, t2;
    bit found;
    logic [2:0] trig3;
    reset = 1'b0; medir = 1'b0; modo = 1'b0; varredura = 1'b0; canal_sel = '0;
    medir3 = 1'b0; canal_sel3 = 2'd3; trig3 = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_trigger", trigger, 0);
    checkOutput("reset_medida", medida, 0);
    checkOutput("reset_pronto", pronto, 0);
    checkOutput("reset_ocupado", ocupado, 0);
    checkOutput("reset_state", db_estado, 0);
    reset = 1'b1;
    @(negedge clock);

    base = pronto_count;
    pushExpected(2, 10, 37);
    applyStimulus(2, 1'b0);
    waitPronto(base + 1, 1000);

    // Out-of-range channel on the 3-sensor instance must fall back to channel 0.
    @(negedge clock); medir3 = 1'b1;
    @(negedge clock); medir3 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(posedge clock);
      #1;
      if (trigger3 != '0) trig3 = trigger3;
      if (pronto3) found = 1'b1;
    end
    checkOutput("n3_done", found, 1);
    checkOutput("n3_trigger", trig3, 1);
    checkOutput("n3_canal", canal_medida3, 0);
    checkOutput("n3_timeout", timeout3, 1);
    checkOutput("n3_medida", medida3, ALL1);
    checkOutput("n3_state", db_estado3, 15);
    checkOutput("n3_ocupado", ocupado3, 1);

    base = pronto_count;
    pushExpected(1, 1, 0);
    applyStimulus(1, 1'b0);
    waitPronto(base + 1, 1000);
    checkRange("timeout_latency", pronto_cyc - trig_fall_cyc, TO - 3, TO + 3);

    base = pronto_count;
    pushExpected(3, 5, 500);
    applyStimulus(3, 1'b0);
    waitPronto(base + 1, 1000);
    checkOutput("state_after_timeout", db_estado, 0);
    repeat (400) @(negedge clock);

    base = pronto_count;
    pushExpected(0, 3, 10);
    pushExpected(1, 7, 20);
    pushExpected(2, 2, 30);
    pushExpected(3, 11, 40);
    busy_drops = 0;
    applyStimulus(0, 1'b1);
    watch_busy = 1'b1;
    waitPronto(base + 4, 3000);
    watch_busy = 1'b0;
    varredura  = 1'b0;
    checkOutput("busy_during_sweep", busy_drops, 0);

    base = pronto_count;
    for (int k = 0; k < 3; k++) pushExpected(0, 4, 15);
    @(negedge clock);
    canal_sel = '0;
    modo      = 1'b1;
    waitPronto(base + 1, 1500);
    t1 = pronto_cyc;
    waitPronto(base + 2, 1500);
    t2 = pronto_cyc;
    checkRange("auto_spacing", t2 - t1, PER + TRIG + 4 + 15, PER + TRIG + 4 + 15 + 8);
    waitState(4'h4, 1000);
    modo = 1'b0;
    waitPronto(base + 3, 1000);
    checkOutput("state_after_auto", db_estado, 0);

    for (int i = 0; i < 8; i++) begin
      int ch;
      bit sw;
      base = pronto_count;
      sw   = ($urandom_range(0, 3) == 0);
      if (sw) begin
        for (int c = 0; c < N; c++) pushExpected(c, $urandom_range(1, 40), $urandom_range(1, 120));
        applyStimulus(0, 1'b1);
        waitPronto(base + N, 4000);
      end else begin
        ch = $urandom_range(0, N - 1);
        pushExpected(ch, $urandom_range(1, 40), $urandom_range(1, 120));
        applyStimulus(ch, 1'b0);
        waitPronto(base + 1, 1000);
      end
      varredura = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clock);
    end

    cfg_width[2] = 0;
    applyStimulus(2, 1'b0);
    waitState(4'h2, 50);
    trig_check_en = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst_mid_trigger", trigger, 0);
    checkOutput("rst_mid_medida", medida, 0);
    checkOutput("rst_mid_pronto", pronto, 0);
    checkOutput("rst_mid_timeout", timeout, 0);
    checkOutput("rst_mid_state", db_estado, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    trig_check_en = 1'b1;
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
